// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU port A, secondary port B and DMEM bus bundle around the arbiter.
interface dmem_arbiter_if #(parameter int DEPTH_LOG2 = 11);
  logic                  a_req, a_we, a_stall;
  logic [31:0]           a_addr, a_wdata, a_rdata;
  logic                  b_req, b_we, b_ack, b_err;
  logic [31:0]           b_addr, b_wdata, b_rdata;
  logic                  dm_ena, dm_w, dm_r;
  logic [DEPTH_LOG2-1:0] dm_addr;
  logic [31:0]           dm_wdata, dm_rdata;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, dm_rdata,
    output a_rdata, a_stall, b_ack, b_err, b_rdata, dm_ena, dm_w, dm_r, dm_addr, dm_wdata
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, dm_rdata,
    input  a_rdata, a_stall, b_ack, b_err, b_rdata, dm_ena, dm_w, dm_r, dm_addr, dm_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port DMEM between CPU port A and requester B with bounded B wait.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          DEPTH_LOG2 = 11,
  parameter int          MAX_WAIT   = 4
) (
  input logic           clk_in,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE_B, RESP} state_e;
  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        b_ack_q, b_err_q;
  logic [31:0] b_rdata_q;
  logic [31:0] a_off, b_off;
  logic        b_bad, serve, go;
  logic        unused_ok;
  always_comb begin
    a_off         = bus.a_addr - BASE_ADDR;
    b_off         = bus.b_addr - BASE_ADDR;
    b_bad         = (|b_off[1:0]) | (|b_off[31:DEPTH_LOG2+2]);
    serve         = state_q == SERVE_B;
    go            = bus.b_req & (~bus.a_req | (wait_q == 4'(MAX_WAIT)));
    state_d       = state_q == IDLE ? (go ? SERVE_B : IDLE) : (serve ? RESP : IDLE);
    wait_d        = (state_q != IDLE || !bus.b_req) ? 4'd0 :
                    (bus.a_req && !go && wait_q != 4'(MAX_WAIT)) ? wait_q + 4'd1 : wait_q;
    bus.dm_ena    = serve ? ~b_bad : bus.a_req;
    bus.dm_w      = serve ? ~b_bad & bus.b_we : bus.a_req & bus.a_we;
    bus.dm_r      = serve ? ~b_bad & ~bus.b_we : bus.a_req & ~bus.a_we;
    bus.dm_addr   = serve ? b_off[DEPTH_LOG2+1:2] : a_off[DEPTH_LOG2+1:2];
    bus.dm_wdata  = serve ? bus.b_wdata : bus.a_wdata;
    bus.a_rdata   = bus.dm_rdata;
    bus.a_stall   = serve;
    bus.b_ack     = b_ack_q;
    bus.b_err     = b_err_q;
    bus.b_rdata   = b_rdata_q;
    unused_ok     = ^{a_off[31:DEPTH_LOG2+2], a_off[1:0]};
  end
  // b_ack/b_err are loaded in SERVE_B so they are high exactly during RESP
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= 4'd0;
      b_ack_q   <= 1'b0;
      b_err_q   <= 1'b0;
      b_rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      b_ack_q <= serve;
      b_err_q <= serve & b_bad;
      if (serve && !b_bad && !bus.b_we) b_rdata_q <= bus.dm_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural DMEM.
module tb_dmem_arbiter;
  localparam int DL = 11;
  localparam logic [31:0] BASE = 32'h1001_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int errs = 0;
  logic [31:0] mem [2**DL];
  logic [31:0] ref_mem [2**DL];
  logic [31:0] exp_brdata = 32'd0;
  logic [32:0] sb [$];
  always #5 clk = ~clk;
  dmem_arbiter_if #(.DEPTH_LOG2(DL)) bus ();
  dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL), .MAX_WAIT(4)) dut (
    .clk_in(clk), .reset(rst), .bus(bus)
  );
  always @(posedge clk) if (bus.dm_ena && bus.dm_w) mem[bus.dm_addr] <= bus.dm_wdata;
  assign bus.dm_rdata = mem[bus.dm_addr];

  task automatic b_access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                          input int exp_lat, input bit hold);
    logic [31:0] off;
    logic err;
    int idx, lat, stalls, acks;
    logic [32:0] e;
    off = addr - BASE;
    err = (off[1:0] != 2'd0) || (off[31:DL+2] != '0);
    idx = int'(off[DL+1:2]);
    if (!err && !we) exp_brdata = ref_mem[idx];
    if (!err && we) ref_mem[idx] = wd;
    sb.push_back({err, exp_brdata});
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    lat = 0; stalls = 0; acks = 0;
    for (int k = 1; k <= 30 && acks == 0; k++) begin
      @(negedge clk); #1;
      if (bus.a_stall) begin
        stalls++;
        vec++;
        if (bus.dm_ena !== !err) begin
          errs++; $display("FAIL b_dm_ena addr=%h got %b want %b", addr, bus.dm_ena, !err);
        end
      end
      if (bus.b_ack) begin
        acks++; lat = k;
        e = sb.pop_front();
        vec++;
        if (bus.b_err !== e[32]) begin
          errs++; $display("FAIL b_err addr=%h got %b want %b", addr, bus.b_err, e[32]);
        end
        vec++;
        if (bus.b_rdata !== e[31:0]) begin
          errs++; $display("FAIL b_rdata addr=%h got %h want %h", addr, bus.b_rdata, e[31:0]);
        end
        if (!hold) bus.b_req = 1'b0;
      end
    end
    vec++;
    if (acks == 0) begin
      errs++; $display("FAIL b_timeout addr=%h got no ack want ack", addr);
      void'(sb.pop_front());
      bus.b_req = 1'b0;
    end else if (lat != exp_lat) begin
      errs++; $display("FAIL b_latency addr=%h got %0d want %0d", addr, lat, exp_lat);
    end
    if (hold) begin
      @(negedge clk); #1;
      if (bus.b_ack) acks++;
      if (bus.a_stall) stalls++;
      bus.b_req = 1'b0;
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (bus.b_ack) acks++;
      if (bus.a_stall) stalls++;
    end
    vec++;
    if (acks != 1) begin errs++; $display("FAIL b_ack_count addr=%h got %0d want 1", addr, acks); end
    vec++;
    if (stalls != 1) begin errs++; $display("FAIL a_stall_count addr=%h got %0d want 1", addr, stalls); end
    vec++;
    if (bus.b_ack !== 1'b0 || bus.b_err !== 1'b0) begin
      errs++; $display("FAIL b_deassert got ack=%b err=%b want 0 0", bus.b_ack, bus.b_err);
    end
    vec++;
    if (bus.b_rdata !== exp_brdata) begin
      errs++; $display("FAIL b_rdata_hold got %h want %h", bus.b_rdata, exp_brdata);
    end
  endtask

  task automatic a_write(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] off;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = addr; bus.a_wdata = wd;
    off = addr - BASE;
    ref_mem[int'(off[DL+1:2])] = wd;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    vec++;
    if (bus.a_stall !== 1'b0 || bus.b_ack !== 1'b0 || bus.b_err !== 1'b0) begin
      errs++; $display("FAIL reset_flags got stall=%b ack=%b err=%b want 0 0 0", bus.a_stall, bus.b_ack, bus.b_err);
    end
    vec++;
    if (bus.b_rdata !== 32'd0) begin errs++; $display("FAIL reset_rdata got %h want 0", bus.b_rdata); end
    vec++;
    if (bus.dm_ena !== 1'b0) begin errs++; $display("FAIL reset_dm_ena got %b want 0", bus.dm_ena); end
    rst = 1'b0;
  endtask

  task automatic test_a_only();
    logic [32:0] e;
    a_write(BASE + 32'd8, 32'hDEAD_BEEF); #1;
    vec++;
    if (bus.dm_addr !== 11'd2) begin errs++; $display("FAIL a_dm_addr got %0d want 2", bus.dm_addr); end
    vec++;
    if (bus.dm_w !== 1'b1 || bus.dm_ena !== 1'b1) begin
      errs++; $display("FAIL a_dm_w got w=%b ena=%b want 1 1", bus.dm_w, bus.dm_ena);
    end
    vec++;
    if (bus.a_stall !== 1'b0) begin errs++; $display("FAIL a_stall got %b want 0", bus.a_stall); end
    a_write(BASE, 32'h0000_A5A5);
    a_write(BASE + 32'd4, 32'h1234_5678);
    a_write(BASE - 32'd4, 32'hCAFE_F00D); #1;
    vec++;
    if (bus.dm_addr !== 11'h7FF) begin errs++; $display("FAIL a_wrap got %h want 7ff", bus.dm_addr); end
    foreach (sb[i]) sb.delete(i);
    @(negedge clk);
    bus.a_we = 1'b0; bus.a_addr = BASE + 32'd8; #1;
    sb.push_back({1'b0, ref_mem[2]});
    e = sb.pop_front();
    vec++;
    if (bus.a_rdata !== e[31:0]) begin errs++; $display("FAIL a_read got %h want %h", bus.a_rdata, e[31:0]); end
    vec++;
    if (bus.dm_r !== 1'b1 || bus.dm_w !== 1'b0) begin
      errs++; $display("FAIL a_read_ctl got r=%b w=%b want 1 0", bus.dm_r, bus.dm_w);
    end
    @(negedge clk);
    bus.a_addr = BASE - 32'd4; #1;
    sb.push_back({1'b0, ref_mem[2047]});
    e = sb.pop_front();
    vec++;
    if (bus.a_rdata !== e[31:0]) begin errs++; $display("FAIL a_read_wrap got %h want %h", bus.a_rdata, e[31:0]); end
    @(negedge clk);
    bus.a_req = 1'b0; #1;
    vec++;
    if (bus.dm_ena !== 1'b0) begin errs++; $display("FAIL a_idle_ena got %b want 0", bus.dm_ena); end
  endtask

  task automatic test_b_idle();
    b_access(BASE + 32'd8, 1'b0, 32'd0, 2, 1'b0);
  endtask

  task automatic test_b_write();
    b_access(BASE + 32'd12, 1'b1, 32'h0BAD_F00D, 2, 1'b0);
    b_access(BASE + 32'd12, 1'b0, 32'd0, 2, 1'b0);
    b_access(BASE + 32'h1FFC, 1'b0, 32'd0, 2, 1'b0);
  endtask

  task automatic test_starvation();
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = BASE;
    b_access(BASE + 32'd4, 1'b0, 32'd0, 6, 1'b0);
    b_access(BASE, 1'b0, 32'd0, 6, 1'b0);
    bus.a_req = 1'b0;
  endtask

  task automatic test_b_error();
    b_access(BASE + 32'd6, 1'b1, 32'hBAD0_BAD0, 2, 1'b0);
    b_access(BASE + 32'h2000, 1'b1, 32'hBAD1_BAD1, 2, 1'b0);
    b_access(BASE + 32'h2000, 1'b0, 32'd0, 2, 1'b0);
    vec++;
    if (mem[1] !== ref_mem[1]) begin errs++; $display("FAIL err_mem1 got %h want %h", mem[1], ref_mem[1]); end
    vec++;
    if (mem[0] !== ref_mem[0]) begin errs++; $display("FAIL err_mem0 got %h want %h", mem[0], ref_mem[0]); end
  endtask

  task automatic test_back_to_back();
    b_access(BASE + 32'd8, 1'b0, 32'd0, 2, 1'b1);
    b_access(BASE + 32'd4, 1'b0, 32'd0, 2, 1'b1);
  endtask

  task automatic test_reset_serve();
    int acks;
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = BASE + 32'd16; bus.b_wdata = 32'h5555_AAAA;
    @(negedge clk); #1;
    vec++;
    if (bus.a_stall !== 1'b1) begin errs++; $display("FAIL rs_serve got stall=%b want 1", bus.a_stall); end
    rst = 1'b1; bus.b_req = 1'b0;
    @(negedge clk); #1;
    vec++;
    if (bus.b_ack !== 1'b0 || bus.a_stall !== 1'b0) begin
      errs++; $display("FAIL rs_flags got ack=%b stall=%b want 0 0", bus.b_ack, bus.a_stall);
    end
    vec++;
    if (bus.b_rdata !== 32'd0) begin errs++; $display("FAIL rs_rdata got %h want 0", bus.b_rdata); end
    rst = 1'b0; exp_brdata = 32'd0; acks = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (bus.b_ack) acks++;
    end
    vec++;
    if (acks != 0) begin errs++; $display("FAIL rs_no_ack got %0d want 0", acks); end
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 32'd0; bus.a_wdata = 32'd0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 32'd0; bus.b_wdata = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_a_only();
    test_b_idle();
    test_b_write();
    test_starvation();
    test_b_error();
    test_back_to_back();
    test_reset_serve();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
